// File: rtl/alien_march_ctrl.sv
// rtl/alien_march_ctrl.sv - alien formation march controller (optional MARCH_SPEEDUP_EN: alive-count step-rate divider)
module alien_march_ctrl #(
  parameter logic [10:0] X_START     = 11'd0,
  parameter logic [10:0] X_MIN       = 11'd0,
  parameter logic [10:0] X_MAX       = 11'd256,
  parameter logic [10:0] STEP_X      = 11'd8,
  parameter logic [10:0] STEP_Y      = 11'd16,
  parameter logic [10:0] Y_LIMIT     = 11'd320,
  parameter logic [5:0]  DIV4_THRESH = 6'd24,
  parameter logic [5:0]  DIV2_THRESH = 6'd8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        tick,
  input  logic        start,
  input  logic        freeze,
  input  logic [5:0]  alive_count,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        dir_right,
  output logic        step_pulse,
  output logic        landed,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MARCH   = 2'd1,
    LANDED  = 2'd2,
    CLEARED = 2'd3
  } state_t;

`ifdef MARCH_SPEEDUP_EN
  localparam logic SPEEDUP = 1'b1;
`else
  localparam logic SPEEDUP = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [10:0] offset_x_q, offset_x_d;
  logic [10:0] offset_y_q, offset_y_d;
  logic        dir_right_q, dir_right_d;
  logic        step_pulse_q, step_pulse_d;
  logic        landed_q, landed_d;
  logic [1:0]  tick_cnt_q, tick_cnt_d;

  logic [2:0]  div_w;
  logic [2:0]  cnt_next_w;
  logic [11:0] right_x_w;
  logic [11:0] down_y_w;
  logic        can_right_w;
  logic        can_left_w;
  logic        hit_limit_w;

  // Fewer live aliens -> faster march; without the speedup every qualified tick steps.
  always_comb begin
    div_w = 3'd1;
    if (SPEEDUP && (alive_count >= DIV4_THRESH)) begin
      div_w = 3'd4;
    end else if (SPEEDUP && (alive_count >= DIV2_THRESH)) begin
      div_w = 3'd2;
    end
  end

  // 12-bit wall and floor compares so an oversized step can never wrap.
  assign cnt_next_w  = {1'b0, tick_cnt_q} + 3'd1;
  assign right_x_w   = {1'b0, offset_x_q} + {1'b0, STEP_X};
  assign down_y_w    = {1'b0, offset_y_q} + {1'b0, STEP_Y};
  assign can_right_w = right_x_w <= {1'b0, X_MAX};
  assign can_left_w  = {1'b0, offset_x_q} >= ({1'b0, X_MIN} + {1'b0, STEP_X});
  assign hit_limit_w = down_y_w >= {1'b0, Y_LIMIT};

  // Next-state logic: start wins everywhere, then clear check, then tick-driven steps.
  always_comb begin
    state_d      = state_q;
    offset_x_d   = offset_x_q;
    offset_y_d   = offset_y_q;
    dir_right_d  = dir_right_q;
    step_pulse_d = 1'b0;
    landed_d     = landed_q;
    tick_cnt_d   = tick_cnt_q;

    if (start) begin
      state_d     = MARCH;
      offset_x_d  = X_START;
      offset_y_d  = 11'd0;
      dir_right_d = 1'b1;
      tick_cnt_d  = 2'd0;
      landed_d    = 1'b0;
    end else begin
      case (state_q)
        MARCH: begin
          if (alive_count == 6'd0) begin
            state_d = CLEARED;
          end else if (tick && !freeze) begin
            if (cnt_next_w >= div_w) begin
              tick_cnt_d   = 2'd0;
              step_pulse_d = 1'b1;
              if (dir_right_q && can_right_w) begin
                offset_x_d = right_x_w[10:0];
              end else if (!dir_right_q && can_left_w) begin
                offset_x_d = offset_x_q - STEP_X;
              end else begin
                offset_y_d  = down_y_w[10:0];
                dir_right_d = ~dir_right_q;
                if (hit_limit_w) begin
                  landed_d = 1'b1;
                  state_d  = LANDED;
                end
              end
            end else begin
              tick_cnt_d = cnt_next_w[1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers; reset drops step_pulse immediately.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      offset_x_q   <= X_START;
      offset_y_q   <= 11'd0;
      dir_right_q  <= 1'b1;
      step_pulse_q <= 1'b0;
      landed_q     <= 1'b0;
      tick_cnt_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      offset_x_q   <= offset_x_d;
      offset_y_q   <= offset_y_d;
      dir_right_q  <= dir_right_d;
      step_pulse_q <= step_pulse_d;
      landed_q     <= landed_d;
      tick_cnt_q   <= tick_cnt_d;
    end
  end

  assign offsetX    = offset_x_q;
  assign offsetY    = offset_y_q;
  assign dir_right  = dir_right_q;
  assign step_pulse = step_pulse_q;
  assign landed     = landed_q;
  assign state_dbg  = state_q;

endmodule
